led_datapath: RTL and testbench

- Execution datapath that responds to the LED-effect control FSM's command outputs.
- Contains:
  - 8x32 register file
  - 3-bit-op ALU
  - write-data mux
  - LED output register
  - programmable delay counter
- Returns status flags isZero and limit_reached to the FSM.
- The FSM drives all controls registered, one set per state, so every command here is single-cycle and stateless apart from the storage elements.

---
 rtl/led_pkg.sv | 31 +++
 rtl/led_datapath_if.sv | 33 +++
 rtl/led_delay_counter.sv | 34 +++
 rtl/led_datapath.sv | 92 +++++++++
 tb/tb_led_datapath.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared constants for the LED-effect datapath: ALU opcodes, write-data selects,
// conventional register roles and default widths.
package led_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 3;
  localparam int DEF_LED_W  = 8;
  localparam int DEF_CNT_W  = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SHL  = 3'b100;
  localparam logic [2:0] ALU_SHR  = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam logic [1:0] WD_IMM = 2'b00;
  localparam logic [1:0] WD_CNT = 2'b01;
  localparam logic [1:0] WD_ALU = 2'b10;
  localparam logic [1:0] WD_RDA = 2'b11;

  // Register roles the control FSM's programs assume.
  localparam logic [2:0] R_LED   = 3'd0;
  localparam logic [2:0] R_LIMIT = 3'd1;
  localparam logic [2:0] R_DELAY = 3'd2;
  localparam logic [2:0] R_SHIFT = 3'd3;
  localparam logic [2:0] R_TMP   = 3'd4;

endpackage

// File: rtl/led_datapath_if.sv
// Command/status bundle between the LED-effect control FSM (master) and the datapath (slave).
// There is no valid/ready pair: every command is a registered, single-cycle strobe qualified
// only by its own enable, and the status outputs are valid in every cycle.
interface led_datapath_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int LED_W  = 8
) ();
  logic [REG_AW-1:0] ra1;
  logic [REG_AW-1:0] ra2;
  logic [REG_AW-1:0] wa;
  logic              rf_we;
  logic [DATA_W-1:0] imm;
  logic [1:0]        wd_sel;
  logic [2:0]        alu_op;
  logic              ld_we;
  logic              c_enable;
  logic              c_limit_we;
  logic              c_reset;
  logic              isZero;
  logic              limit_reached;
  logic [LED_W-1:0]  leds;

  modport master (
    output ra1, ra2, wa, rf_we, imm, wd_sel, alu_op, ld_we, c_enable, c_limit_we, c_reset,
    input  isZero, limit_reached, leds
  );

  modport slave (
    input  ra1, ra2, wa, rf_we, imm, wd_sel, alu_op, ld_we, c_enable, c_limit_we, c_reset,
    output isZero, limit_reached, leds
  );
endinterface

// File: rtl/led_delay_counter.sv
// Programmable delay counter: counts enabled cycles up to a loaded limit and saturates there.
module led_delay_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_enable,
  input  logic             c_limit_we,
  input  logic             c_reset,
  input  logic [CNT_W-1:0] limit_d,
  output logic [CNT_W-1:0] count,
  output logic             limit_reached
);
  logic [CNT_W-1:0] limit_q;

  // Limit load is independent of clear; clear wins over counting. Counting stops on
  // equality only, so a limit reloaded below the count leaves limit_reached low until cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      limit_q <= '0;
    end else begin
      if (c_limit_we) limit_q <= limit_d;
      if (c_reset) begin
        count <= '0;
      end else if (c_enable && (count != limit_q)) begin
        count <= count + 1'b1;
      end
    end
  end

  assign limit_reached = (count == limit_q);

endmodule

// File: rtl/led_datapath.sv
// LED-effect execution datapath: register file, ALU, write-data mux, LED register and
// delay counter, all driven by single-cycle commands from the control FSM.
module led_datapath
  import led_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int LED_W  = DEF_LED_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic           clk,
  input logic           reset,
  led_datapath_if.slave bus
);
  localparam int NREGS = 2 ** REG_AW;
  localparam int SH_W  = $clog2(DATA_W);

  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] wd;
  logic [SH_W-1:0]   shamt;
  logic [LED_W-1:0]  leds_q;
  logic [CNT_W-1:0]  count;
  logic              limit_reached;

  // Reads are unbypassed: a same-cycle write to the read address still shows the old value.
  assign rd_a  = rf[bus.ra1];
  assign rd_b  = rf[bus.ra2];
  assign shamt = rd_b[SH_W-1:0];

  always_comb begin
    alu_result = '0;
    case (bus.alu_op)
      ALU_ADD:  alu_result = rd_a + rd_b;
      ALU_AND:  alu_result = rd_a & rd_b;
      ALU_OR:   alu_result = rd_a | rd_b;
      ALU_SUB:  alu_result = rd_a - rd_b;
      ALU_SHL:  alu_result = rd_a << shamt;
      ALU_SHR:  alu_result = rd_a >> shamt;
      ALU_XOR:  alu_result = rd_a ^ rd_b;
      ALU_PASS: alu_result = rd_a;
      default:  alu_result = '0;
    endcase
  end

  always_comb begin
    wd = bus.imm;
    case (bus.wd_sel)
      WD_IMM:  wd = bus.imm;
      WD_CNT:  wd = DATA_W'(count);
      WD_ALU:  wd = alu_result;
      WD_RDA:  wd = rd_a;
      default: wd = bus.imm;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (bus.rf_we) begin
      rf[bus.wa] <= wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q <= '0;
    end else if (bus.ld_we) begin
      leds_q <= rd_a[LED_W-1:0];
    end
  end

  led_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay_counter (
    .clk           (clk),
    .reset         (reset),
    .c_enable      (bus.c_enable),
    .c_limit_we    (bus.c_limit_we),
    .c_reset       (bus.c_reset),
    .limit_d       (CNT_W'(rd_a)),
    .count         (count),
    .limit_reached (limit_reached)
  );

  assign bus.isZero        = (alu_result == '0);
  assign bus.limit_reached = limit_reached;
  assign bus.leds          = leds_q;

endmodule

// File: tb/tb_led_datapath.sv
// Directed bench for led_datapath: a vector table for register/ALU/LED behaviour plus
// hand-written counter, same-edge and asynchronous-reset sequences.
module tb_led_datapath;
  import led_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] exp_q[$];

  led_datapath_if #(.DATA_W(32), .REG_AW(3), .LED_W(8)) bus ();

  led_datapath #(
    .DATA_W (32),
    .REG_AW (3),
    .LED_W  (8),
    .CNT_W  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rf_we;
    logic [2:0]  wa;
    logic [1:0]  wd_sel;
    logic [31:0] imm;
    logic [2:0]  alu_op;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic        ld_we;
    logic        exp_zero;
    logic [7:0]  exp_leds;
    logic        exp_lim;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [1:0] ws,
                              input logic [31:0] imm, input logic [2:0] op, input logic [2:0] a,
                              input logic [2:0] b, input logic ld, input logic ez,
                              input logic [7:0] el, input logic elim);
    vec_t v;
    v.rf_we = we; v.wa = wa; v.wd_sel = ws; v.imm = imm; v.alu_op = op;
    v.ra1 = a; v.ra2 = b; v.ld_we = ld; v.exp_zero = ez; v.exp_leds = el; v.exp_lim = elim;
    return v;
  endfunction

  // Driver tasks
  task automatic idle_ctrl();
    bus.ra1 = '0; bus.ra2 = '0; bus.wa = '0; bus.rf_we = 1'b0; bus.imm = '0;
    bus.wd_sel = WD_IMM; bus.alu_op = ALU_ADD; bus.ld_we = 1'b0;
    bus.c_enable = 1'b0; bus.c_limit_we = 1'b0; bus.c_reset = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] wa, input logic [1:0] ws, input logic [31:0] imm);
    bus.rf_we = 1'b1; bus.wa = wa; bus.wd_sel = ws; bus.imm = imm;
    cyc();
    idle_ctrl();
  endtask

  task automatic load_leds(input logic [2:0] r);
    bus.ra1 = r; bus.ld_we = 1'b1;
    cyc();
    idle_ctrl();
  endtask

  task automatic load_limit_and_clear(input logic [2:0] r);
    bus.ra1 = r; bus.c_limit_we = 1'b1; bus.c_reset = 1'b1;
    cyc();
    idle_ctrl();
  endtask

  task automatic run_enabled(input int n);
    bus.c_enable = 1'b1;
    repeat (n) cyc();
    bus.c_enable = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_ctrl();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    check("rst_leds", bus.leds, 8'h00);
    check("rst_lim", bus.limit_reached, 1'b1);
    check("rst_zero_add", bus.isZero, 1'b1);
    for (int r = 0; r < 8; r++) begin
      bus.alu_op = ALU_PASS; bus.ra1 = 3'(r);
      #1;
      check($sformatf("rst_r%0d_zero", r), bus.isZero, 1'b1);
    end
    idle_ctrl();

    //                we  wa  wd_sel  imm            op        ra1 ra2 ld  zero leds   lim
    tbl[0]  = mk(0, 0, WD_IMM, 32'h0,        ALU_ADD,  0, 0, 0, 1, 8'h00, 1);
    tbl[1]  = mk(1, 0, WD_IMM, 32'h1,        ALU_PASS, 0, 0, 0, 1, 8'h00, 1);
    tbl[2]  = mk(0, 0, WD_IMM, 32'h0,        ALU_PASS, 0, 0, 1, 0, 8'h01, 1);
    tbl[3]  = mk(1, 0, WD_IMM, 32'h40,       ALU_PASS, 0, 0, 0, 0, 8'h01, 1);
    tbl[4]  = mk(1, 3, WD_IMM, 32'h1,        ALU_ADD,  0, 0, 0, 0, 8'h01, 1);
    tbl[5]  = mk(1, 4, WD_ALU, 32'h0,        ALU_SHL,  0, 3, 0, 0, 8'h01, 1);
    tbl[6]  = mk(1, 0, WD_RDA, 32'h0,        ALU_PASS, 4, 0, 1, 0, 8'h80, 1);
    tbl[7]  = mk(1, 1, WD_IMM, 32'h80,       ALU_SUB,  0, 1, 0, 0, 8'h80, 1);
    tbl[8]  = mk(0, 0, WD_IMM, 32'h0,        ALU_SUB,  0, 1, 0, 1, 8'h80, 1);
    tbl[9]  = mk(1, 0, WD_IMM, 32'h40,       ALU_SUB,  0, 1, 0, 1, 8'h80, 1);
    tbl[10] = mk(0, 0, WD_IMM, 32'h0,        ALU_SUB,  0, 1, 0, 0, 8'h80, 1);
    tbl[11] = mk(0, 0, WD_IMM, 32'h0,        ALU_AND,  0, 1, 0, 1, 8'h80, 1);
    tbl[12] = mk(0, 0, WD_IMM, 32'h0,        ALU_OR,   0, 1, 0, 0, 8'h80, 1);
    tbl[13] = mk(0, 0, WD_IMM, 32'h0,        ALU_XOR,  1, 1, 0, 1, 8'h80, 1);
    tbl[14] = mk(1, 5, WD_IMM, 32'h21,       ALU_XOR,  1, 4, 0, 1, 8'h80, 1);
    tbl[15] = mk(1, 6, WD_ALU, 32'h0,        ALU_SHR,  1, 5, 0, 0, 8'h80, 1);
    tbl[16] = mk(0, 0, WD_IMM, 32'h0,        ALU_PASS, 6, 0, 1, 0, 8'h40, 1);
    tbl[17] = mk(1, 7, WD_IMM, 32'hFFFFFFFF, ALU_PASS, 7, 0, 0, 1, 8'h40, 1);
    tbl[18] = mk(0, 0, WD_IMM, 32'h0,        ALU_ADD,  7, 3, 0, 1, 8'h40, 1);
    tbl[19] = mk(1, 2, WD_ALU, 32'h0,        ALU_AND,  7, 0, 1, 0, 8'hFF, 1);
    tbl[20] = mk(0, 0, WD_IMM, 32'h0,        ALU_SHL,  3, 5, 0, 0, 8'hFF, 1);
    tbl[21] = mk(0, 0, WD_IMM, 32'h0,        ALU_XOR,  7, 7, 1, 1, 8'hFF, 1);

    foreach (tbl[i]) begin
      bus.rf_we = tbl[i].rf_we; bus.wa = tbl[i].wa; bus.wd_sel = tbl[i].wd_sel;
      bus.imm = tbl[i].imm; bus.alu_op = tbl[i].alu_op; bus.ra1 = tbl[i].ra1;
      bus.ra2 = tbl[i].ra2; bus.ld_we = tbl[i].ld_we;
      #1;
      check($sformatf("vec%0d_zero", i), bus.isZero, tbl[i].exp_zero);
      exp_q.push_back({24'h0, tbl[i].exp_leds});
      cyc();
      check($sformatf("vec%0d_leds", i), bus.leds, exp_q.pop_front());
      check($sformatf("vec%0d_lim", i), bus.limit_reached, tbl[i].exp_lim);
    end
    idle_ctrl();

    // Counter: limit 5 needs exactly five enabled cycles, then saturates.
    wr(3'd2, WD_IMM, 32'd5);
    load_limit_and_clear(3'd2);
    #1;
    check("cnt_loaded_lim", bus.limit_reached, 1'b0);
    bus.c_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("cnt_pre%0d", i), bus.limit_reached, 1'b0);
      cyc();
    end
    check("cnt_reached", bus.limit_reached, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("cnt_sat%0d", i), bus.limit_reached, 1'b1);
    end
    idle_ctrl();
    wr(3'd4, WD_CNT, 32'h0);
    load_leds(3'd4);
    check("cnt_capture5", bus.leds, 8'h05);

    // Same-edge clear and enable at count 3; r6 captures the pre-edge count.
    bus.c_reset = 1'b1;
    cyc();
    idle_ctrl();
    run_enabled(3);
    check("same_edge_pre_lim", bus.limit_reached, 1'b0);
    bus.c_reset = 1'b1; bus.c_enable = 1'b1;
    bus.rf_we = 1'b1; bus.wa = 3'd6; bus.wd_sel = WD_CNT;
    cyc();
    idle_ctrl();
    wr(3'd4, WD_CNT, 32'h0);
    load_leds(3'd6);
    check("same_edge_cnt3", bus.leds, 8'h03);
    load_leds(3'd4);
    check("same_edge_cnt0", bus.leds, 8'h00);
    check("same_edge_lim", bus.limit_reached, 1'b0);

    // Limit reloaded below the count: never reached until cleared.
    run_enabled(4);
    wr(3'd3, WD_IMM, 32'd2);
    bus.ra1 = 3'd3; bus.c_limit_we = 1'b1;
    cyc();
    idle_ctrl();
    check("below_lim_load", bus.limit_reached, 1'b0);
    bus.c_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("below_run%0d", i), bus.limit_reached, 1'b0);
    end
    idle_ctrl();
    bus.c_reset = 1'b1;
    cyc();
    idle_ctrl();
    check("below_clr", bus.limit_reached, 1'b0);
    bus.c_enable = 1'b1;
    cyc();
    check("below_cnt1", bus.limit_reached, 1'b0);
    cyc();
    check("below_cnt2", bus.limit_reached, 1'b1);
    cyc();
    check("below_sat", bus.limit_reached, 1'b1);
    idle_ctrl();
    wr(3'd4, WD_CNT, 32'h0);
    load_leds(3'd4);
    check("below_capture2", bus.leds, 8'h02);

    // Asynchronous reset in the middle of a count.
    load_limit_and_clear(3'd2);
    run_enabled(2);
    load_leds(3'd7);
    check("arst_pre_leds", bus.leds, 8'hFF);
    check("arst_pre_lim", bus.limit_reached, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_leds", bus.leds, 8'h00);
    check("arst_lim", bus.limit_reached, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int r = 0; r < 8; r++) begin
      bus.alu_op = ALU_PASS; bus.ra1 = 3'(r);
      #1;
      check($sformatf("arst_r%0d_zero", r), bus.isZero, 1'b1);
    end
    idle_ctrl();
    run_enabled(2);
    check("arst_lim0_hold", bus.limit_reached, 1'b1);
    wr(3'd0, WD_CNT, 32'h0);
    bus.alu_op = ALU_PASS; bus.ra1 = 3'd0;
    #1;
    check("arst_cnt0", bus.isZero, 1'b1);
    idle_ctrl();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
